// File: rtl/fib_pkg.sv
// Shared types and default sizing for the Fibonacci BCD display path.
package fib_pkg;

  localparam int unsigned FIB_WIDTH  = 16;
  localparam int unsigned FIB_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } fib_state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the next
// left shift carries into the digit above instead of producing a value above 9.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/fib_bcd_converter.sv
// Serial binary-to-BCD converter (double dabble), one bit per cycle.
// Define LEADING_ZERO_BLANK_EN to generate per-digit leading-zero blank flags.
module fib_bcd_converter
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH  = FIB_WIDTH,
  parameter int unsigned DIGITS = FIB_DIGITS
) (
  input  logic                  clk,
  input  logic                  usr_reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  fib_state_e          r_state;
  logic [WIDTH-1:0]    r_shift;
  logic [4*DIGITS-1:0] r_scratch;
  logic [4*DIGITS-1:0] r_bcd;
  logic [4*DIGITS-1:0] w_corr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit(r_scratch[4*g +: 4]),
      .o_digit(w_corr[4*g +: 4])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_hi_zero;

  // Digit 0 is never blanked so a zero result still shows "0".
  always_comb begin
    w_blank   = '0;
    w_hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_hi_zero  = w_hi_zero & (r_scratch[4*i +: 4] == 4'd0);
      w_blank[i] = w_hi_zero;
    end
  end

  assign blank = r_blank;
`else
  assign blank = '0;
`endif

  always_ff @(posedge clk) begin
    r_done <= 1'b0;
    if (!usr_reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      r_blank   <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_shift   <= bin_in;
            r_scratch <= '0;
            r_cnt     <= CNT_W'(WIDTH);
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Correct then shift; the shift truncates to the register width.
          {r_scratch, r_shift} <= {w_corr, r_shift} << 1;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_bcd   <= r_scratch;
`ifdef LEADING_ZERO_BLANK_EN
          r_blank <= w_blank;
`endif
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Scoreboard bench for fib_bcd_converter: stimulus queues expectations, a negedge
// monitor pops and checks them whenever done pulses.
module tb_fib_bcd_converter;

  localparam int W = 16;
  localparam int D = 5;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           usr_reset;
  logic           start;
  logic [W-1:0]   bin_in;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;
  logic [D-1:0]   blank;

  typedef struct {
    logic [4*D-1:0] bcd;
    logic [D-1:0]   blank;
    int             t0;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  fib_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
    .clk      (clk),
    .usr_reset(usr_reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .blank    (blank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [D-1:0] blk(input logic [D-1:0] on);
`ifdef LEADING_ZERO_BLANK_EN
    return on;
`else
    return on & '0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no pulse (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("bcd", 32'(bcd), 32'(e.bcd));
        check("blank", 32'(blank), 32'(e.blank));
        check("latency", 32'(cyc - e.t0), 32'(LAT));
      end
    end
  end

  // Drive start for one sampling edge and queue the expected result.
  task automatic issue(input logic [W-1:0] v, input logic [4*D-1:0] eb, input logic [D-1:0] ebl);
    exp_t e;
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    e.bcd   = eb;
    e.blank = blk(ebl);
    e.t0    = cyc;
    exp_q.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy === 1'b0 && done === 1'b0) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL drain_timeout: got %0d pending busy=%b, expected idle within %0d cycles",
             exp_q.size(), busy, budget);
  endtask

  initial begin
    int t0;
    usr_reset = 1'b0;
    start     = 1'b0;
    bin_in    = '0;
    repeat (3) @(posedge clk);
    #1 usr_reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);

    issue(16'd0, 20'h00000, 5'b11110);
    @(negedge clk);
    check("busy_in_shift", 32'(busy), 32'd1);
    wait_drain(40);

    issue(16'd987, 20'h00987, 5'b11000);
    wait_drain(40);

    // bcd must hold the previous result while the next conversion runs.
    issue(16'd65535, 20'h65535, 5'b00000);
    repeat (5) @(negedge clk);
    check("bcd_hold", 32'(bcd), 32'h00987);
    check("busy_mid", 32'(busy), 32'd1);
    wait_drain(40);

    // Second start three cycles later is ignored.
    issue(16'd55, 20'h00055, 5'b11100);
    repeat (2) @(posedge clk);
    #1;
    start  = 1'b1;
    bin_in = 16'd89;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain(40);
    issue(16'd89, 20'h00089, 5'b11100);
    wait_drain(40);

    // Reset at cycle 8 of a conversion aborts it without a done pulse.
    start  = 1'b1;
    bin_in = 16'd4181;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 usr_reset = 1'b0;
    @(posedge clk);
    #1 usr_reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd), 32'h0);
    check("abort_blank", 32'(blank), 32'h0);
    repeat (30) @(negedge clk);
    check("abort_stays_idle", 32'(busy), 32'd0);

    // start held high: a new conversion is accepted every LAT+1 cycles.
    start  = 1'b1;
    bin_in = 16'd144;
    @(posedge clk);
    #1 t0 = cyc;
    for (int j = 0; j < 3; j++) begin
      exp_t e;
      e.bcd   = 20'h00144;
      e.blank = blk(5'b11000);
      e.t0    = t0 + j * (LAT + 1);
      exp_q.push_back(e);
    end
    repeat (39) @(posedge clk);
    #1 start = 1'b0;
    wait_drain(100);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
